// File: rtl/seq_multiplier_if.sv
// Operand/result bundle for seq_multiplier: start/operands in, busy/done/product out.
interface seq_multiplier_if #(
  parameter int unsigned WIDTH = 8
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier, WIDTH cycles per product, signed or unsigned operands.
// Operates on magnitudes and fixes the sign on the final partial sum.
module seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  seq_multiplier_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH:0]     mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] product_q;

  logic               accept;
  logic               last;
  logic [WIDTH:0]     a_ext, b_ext, a_mag, b_mag;
  logic [2*WIDTH-1:0] acc_sum;

  assign accept = bus.start && (state_q != StCalc);
  assign last   = (state_q == StCalc) && (cnt_q == CntW'(WIDTH - 1));

  // One extra bit so the most negative operand has a representable magnitude.
  always_comb begin
    a_ext   = {bus.signed_mode & bus.a[WIDTH-1], bus.a};
    b_ext   = {bus.signed_mode & bus.b[WIDTH-1], bus.b};
    a_mag   = a_ext[WIDTH] ? -a_ext : a_ext;
    b_mag   = b_ext[WIDTH] ? -b_ext : b_ext;
    acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StCalc;
      StCalc:  if (last)      state_d = StDone;
      StDone:  state_d = bus.start ? StCalc : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy    = (state_q == StCalc);
    bus.done    = (state_q == StDone);
    bus.product = product_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else if (accept) begin
      cnt_q    <= '0;
      mcand_q  <= {{(WIDTH-1){1'b0}}, a_mag};
      mplier_q <= b_mag;
      acc_q    <= '0;
      neg_q    <= a_ext[WIDTH] ^ b_ext[WIDTH];
    end else if (state_q == StCalc) begin
      cnt_q    <= cnt_q + 1'b1;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_sum;
      // Only the completed sum reaches product, never a partial one.
      if (last) begin
        product_q <= neg_q ? -acc_sum : acc_sum;
      end
    end
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request to begin a multiply; sampled on rising clk.
REQ-005 The block SHALL have port signed_mode, input, 1: 1 = two's-complement operands, 0 = unsigned.
REQ-006 The block SHALL have port a, input, WIDTH, multiplicand.
REQ-007 The block SHALL have port b, input, WIDTH, multiplier.
REQ-008 The block SHALL have port busy, output, 1: high while a multiply is in progress.
REQ-009 The block SHALL have port done, output, 1: one-cycle pulse when product is valid.
REQ-010 The block SHALL have port product, output, 2*WIDTH, registered result.

Function
REQ-011 The FSM SHALL have states IDLE, CALC and DONE.
REQ-012 Transitions SHALL be: IDLE->CALC on start=1; CALC->DONE after WIDTH CALC cycles; DONE->CALC on start=1; DONE->IDLE otherwise.
REQ-013 Accept: start=1 in IDLE or DONE SHALL capture a, b and signed_mode at that edge; later input changes do not affect the operation.
REQ-014 In CALC, start SHALL be ignored (no queuing, no restart).
REQ-015 Core: radix-2 shift-add on operand magnitudes, one partial product per cycle, with a bit counter running 0..WIDTH-1.
REQ-016 Signed mode: magnitudes SHALL be taken as two's-complement absolute values, computed at WIDTH+1 bits so that the most negative value is handled correctly.
REQ-017 Signed mode: the unsigned result SHALL be negated when the operand sign bits differ.
REQ-018 product SHALL be the exact 2*WIDTH-bit result; no overflow is possible in either mode.
REQ-019 Latency: product SHALL be updated and done asserted exactly WIDTH clk cycles after the accept edge.
REQ-020 done SHALL be high only for the single cycle spent in DONE.
REQ-021 busy SHALL be high exactly while the state is CALC.
REQ-022 product SHALL hold its value from one completion until the next completion or reset, and SHALL never show partial sums.
REQ-023 A zero operand SHALL still take the full WIDTH cycles; there is no early termination.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, product=0, and clear counter and datapath registers, including mid-operation.
REQ-025 After rst_n deasserts, the first start SHALL be accepted normally with full latency.

Verification (WIDTH=8)
REQ-026 Unsigned 3*2 -> product=0x0006, done pulses exactly 8 cycles after accept, busy high for 8 cycles.
REQ-027 Unsigned 255*255 -> product=0xFE01; unsigned 0x80*0x02 -> 0x0100; the same operands in signed mode -> 0xFF00.
REQ-028 Signed -128*-128 -> 0x4000; signed -1*1 -> 0xFFFF; signed 0*-5 -> 0x0000.
REQ-029 Start 7*5, then during CALC pulse start with 9*9 and change a and b -> product=0x0023, no second done.
REQ-030 Start 15*15, assert rst_n=0 at CALC cycle 4 -> busy, done and product are 0 at once; after release, 1*10 -> 0x000A.
REQ-031 Start asserted in the DONE cycle with 6*7 -> accepted back-to-back; first result stays held until the second done, which shows 0x002A; then 10 random operand/mode pairs match a behavioural reference model.
